// File: rtl/led_uart_tx_pkg.sv
// Shared definitions for the LED UART transmitter: state encodings,
// default bit timing and frame-length constants.
// Optional parity support is enabled by defining LED_UART_PARITY_EN.
package led_uart_tx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200
    localparam int unsigned DEFAULT_CNT_W        = 16;
    localparam int unsigned DATA_BITS            = 8;

`ifdef LED_UART_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;              // start + 8 data + parity + stop
`else
    localparam int unsigned FRAME_BITS = 10;              // start + 8 data + stop
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef LED_UART_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } txState_t;

    // Total clock cycles taken by one frame at a given bit period.
    function automatic int unsigned frameCycles(input int unsigned clksPerBit);
        return FRAME_BITS * clksPerBit;
    endfunction

endpackage

// File: rtl/led_uart_tx_if.sv
// Byte-strobe input and serial/status outputs of the LED UART transmitter.
interface led_uart_tx_if;
    logic [7:0] iData;
    logic       iValid;
    logic       oTx;
    logic       oBusy;
    logic       oHoldFull;
    logic       oOverrun;

    modport master (
        output iData, iValid,
        input  oTx, oBusy, oHoldFull, oOverrun
    );

    modport slave (
        input  iData, iValid,
        output oTx, oBusy, oHoldFull, oOverrun
    );
endinterface

// File: rtl/led_uart_tx_uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count. clear holds the counter at zero. Shared with a future receiver.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running bit-period counter, wraps at the end of each bit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/led_uart_tx.sv
// LED UART transmitter: serializes each LED register write as a UART frame
// (8N1, LSB first) with a one-entry newest-wins holding buffer.
// Define LED_UART_PARITY_EN to add an even-parity bit after the data bits.
module led_uart_tx
    import led_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic          Clock,
    input  logic          Reset,
    led_uart_tx_if.slave  bus
);

    txState_t   state,     stateNext;
    logic [7:0] shiftReg,  shiftNext;
    logic [2:0] bitIdx,    bitIdxNext;
    logic [7:0] holdReg,   holdNext;
    logic       holdFull,  holdFullNext;
    logic       overrun,   overrunNext;
    logic       timerClear;
    logic       tick;
    logic       txLine;
`ifdef LED_UART_PARITY_EN
    logic       parityBit, parityNext;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) bitTimer (
        .Clock (Clock),
        .Reset (Reset),
        .clear (timerClear),
        .tick  (tick)
    );

    // State and datapath registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            shiftReg  <= '0;
            bitIdx    <= '0;
            holdReg   <= '0;
            holdFull  <= 1'b0;
            overrun   <= 1'b0;
`ifdef LED_UART_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            shiftReg  <= shiftNext;
            bitIdx    <= bitIdxNext;
            holdReg   <= holdNext;
            holdFull  <= holdFullNext;
            overrun   <= overrunNext;
`ifdef LED_UART_PARITY_EN
            parityBit <= parityNext;
`endif
        end
    end

    // Next-state, frame launch and holding-buffer update.
    always_comb begin
        stateNext    = state;
        shiftNext    = shiftReg;
        bitIdxNext   = bitIdx;
        holdNext     = holdReg;
        holdFullNext = holdFull;
        overrunNext  = 1'b0;
        timerClear   = (state == IDLE);
`ifdef LED_UART_PARITY_EN
        parityNext   = parityBit;
`endif

        if (state == IDLE) begin
            if (bus.iValid) begin
                stateNext  = START;
                shiftNext  = bus.iData;
                bitIdxNext = '0;
`ifdef LED_UART_PARITY_EN
                parityNext = ^bus.iData;
`endif
            end
        end else if (state == STOP && tick) begin
            // End of frame: a held byte goes first and a simultaneous strobe
            // refills the buffer without counting as an overrun.
            if (holdFull) begin
                stateNext    = START;
                shiftNext    = holdReg;
                bitIdxNext   = '0;
                holdFullNext = bus.iValid;
                if (bus.iValid) begin
                    holdNext = bus.iData;
                end
`ifdef LED_UART_PARITY_EN
                parityNext   = ^holdReg;
`endif
            end else if (bus.iValid) begin
                stateNext  = START;
                shiftNext  = bus.iData;
                bitIdxNext = '0;
`ifdef LED_UART_PARITY_EN
                parityNext = ^bus.iData;
`endif
            end else begin
                stateNext = IDLE;
            end
        end else begin
            if (bus.iValid) begin
                holdNext     = bus.iData;
                holdFullNext = 1'b1;
                overrunNext  = holdFull;
            end
            case (state)
                START: begin
                    if (tick) begin
                        stateNext = DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shiftNext = {1'b0, shiftReg[7:1]};
                        if (bitIdx == 3'd7) begin
                            bitIdxNext = '0;
`ifdef LED_UART_PARITY_EN
                            stateNext  = PARITY;
`else
                            stateNext  = STOP;
`endif
                        end else begin
                            bitIdxNext = bitIdx + 3'd1;
                        end
                    end
                end
`ifdef LED_UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        stateNext = STOP;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Serial line level for the current state.
    always_comb begin
        txLine = 1'b1;
        case (state)
            START:   txLine = 1'b0;
            DATA:    txLine = shiftReg[0];
`ifdef LED_UART_PARITY_EN
            PARITY:  txLine = parityBit;
`endif
            default: txLine = 1'b1;
        endcase
    end

    assign bus.oTx       = txLine;
    assign bus.oBusy     = (state != IDLE);
    assign bus.oHoldFull = holdFull;
    assign bus.oOverrun  = overrun;

endmodule

// File: tb/tb_led_uart_tx.sv
// Scoreboard bench for led_uart_tx at CLKS_PER_BIT=4. Stimulus pushes the
// expected byte and start cycle of each frame; a monitor decodes the TX line.
module tb_led_uart_tx;

    localparam int CPB = 4;
`ifdef LED_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRM = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        int         startCyc;
    } frame_t;

    logic   Clock = 1'b0;
    logic   Reset = 1'b1;
    int     cycle = 0;
    int     c0    = 0;
    int     checks = 0;
    int     errors = 0;
    int     ovCount = 0;
    bit     monEn = 1'b0;
    frame_t expQ[$];

    led_uart_tx_if ledIf ();

    led_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ledIf)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cycle <= cycle + 1;

    always @(negedge Clock) begin
        if (!Reset && ledIf.oOverrun === 1'b1) ovCount <= ovCount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line level expected at bit slot b of a frame carrying d.
    function automatic logic lineBit(input logic [7:0] d, input int b);
        logic [7:0] v;
        v = d;
        if (b == 0) return 1'b0;
        if (b <= 8) return v[b-1];
`ifdef LED_UART_PARITY_EN
        if (b == 9) return ^v;
`endif
        return 1'b1;
    endfunction

    // Advance to the negedge of relative cycle k.
    task automatic waitCyc(input int k);
        while (cycle < c0 + k) @(negedge Clock);
        if (cycle != c0 + k) check("schedule", cycle - c0, k);
    endtask

    task automatic send(input int k, input logic [7:0] d);
        waitCyc(k);
        ledIf.iValid = 1'b1;
        ledIf.iData  = d;
        @(negedge Clock);
        ledIf.iValid = 1'b0;
        ledIf.iData  = 8'h00;
    endtask

    task automatic expectFrame(input logic [7:0] d, input int k);
        frame_t f;
        f.data     = d;
        f.startCyc = c0 + k;
        expQ.push_back(f);
    endtask

    task automatic startTest();
        @(negedge Clock);
        c0 = cycle;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (ledIf.oBusy !== 1'b0 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 300) check("idle timeout", 32'(ledIf.oBusy), 0);
        repeat (3) @(negedge Clock);
    endtask

    // Monitor: decode each frame and compare against the scoreboard queue.
    initial begin
        frame_t e;
        bit     bad;
        int     badAt;
        logic   want;
        forever begin
            @(negedge Clock);
            if (Reset || !monEn) continue;
            if (ledIf.oTx === 1'b0) begin
                if (expQ.size() == 0) begin
                    check("unexpected frame start", cycle - c0, 32'hFFFF_FFFF);
                    continue;
                end
                e = expQ.pop_front();
                check($sformatf("start cycle of 0x%02h", e.data), cycle - c0, e.startCyc - c0);
                bad   = 1'b0;
                badAt = 0;
                for (int i = 0; i < FRM; i++) begin
                    if (i > 0) @(negedge Clock);
                    want = lineBit(e.data, i / CPB);
                    if (ledIf.oTx !== want && !bad) begin
                        bad   = 1'b1;
                        badAt = i;
                    end
                end
                check($sformatf("frame 0x%02h line, first bad offset", e.data), bad ? badAt : -1, -1);
            end
        end
    end

    initial begin
        ledIf.iValid = 1'b0;
        ledIf.iData  = 8'h00;

        // Reset state
        repeat (3) @(negedge Clock);
        check("reset oTx", 32'(ledIf.oTx), 1);
        check("reset oBusy", 32'(ledIf.oBusy), 0);
        check("reset oHoldFull", 32'(ledIf.oHoldFull), 0);
        check("reset oOverrun", 32'(ledIf.oOverrun), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Reset mid-frame with a byte held
        startTest();
        send(0, 8'hFF);
        send(5, 8'h99);
        waitCyc(6);
        check("hold before reset", 32'(ledIf.oHoldFull), 1);
        waitCyc(10);
        Reset = 1'b1;
        #1;
        check("mid-frame reset oTx", 32'(ledIf.oTx), 1);
        check("mid-frame reset oBusy", 32'(ledIf.oBusy), 0);
        check("mid-frame reset oHoldFull", 32'(ledIf.oHoldFull), 0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("post-reset idle oTx", 32'(ledIf.oTx), 1);
        monEn = 1'b1;

        // Clean frame after reset
        startTest();
        expectFrame(8'h01, 1);
        send(0, 8'h01);
        waitIdle();

        // Single byte, busy timing
        startTest();
        expectFrame(8'hA5, 1);
        send(0, 8'hA5);
        waitCyc(1);
        check("A5 busy at launch", 32'(ledIf.oBusy), 1);
        waitCyc(FRM);
        check("A5 busy last cycle", 32'(ledIf.oBusy), 1);
        waitCyc(FRM + 1);
        check("A5 busy after frame", 32'(ledIf.oBusy), 0);
        waitIdle();

        // Back-to-back through the holding buffer
        startTest();
        expectFrame(8'h3C, 1);
        expectFrame(8'hC3, FRM + 1);
        send(0, 8'h3C);
        waitCyc(8);
        check("b2b hold before", 32'(ledIf.oHoldFull), 0);
        send(8, 8'hC3);
        check("b2b hold set", 32'(ledIf.oHoldFull), 1);
        waitCyc(FRM + 1);
        check("b2b hold drained", 32'(ledIf.oHoldFull), 0);
        check("b2b no gap busy", 32'(ledIf.oBusy), 1);
        waitIdle();

        // Overrun: newest held byte wins
        startTest();
        expectFrame(8'h11, 1);
        expectFrame(8'h33, FRM + 1);
        send(0, 8'h11);
        send(8, 8'h22);
        send(12, 8'h33);
        check("overrun pulse", 32'(ledIf.oOverrun), 1);
        waitCyc(14);
        check("overrun one cycle", 32'(ledIf.oOverrun), 0);
        waitIdle();

        // Final-STOP collision with a full hold
        startTest();
        expectFrame(8'h44, 1);
        expectFrame(8'h55, FRM + 1);
        expectFrame(8'h66, 2 * FRM + 1);
        send(0, 8'h44);
        send(8, 8'h55);
        send(FRM, 8'h66);
        check("collision no overrun", 32'(ledIf.oOverrun), 0);
        check("collision hold refilled", 32'(ledIf.oHoldFull), 1);
        waitIdle();

        // Final-STOP strobe with empty hold launches directly
        startTest();
        expectFrame(8'h81, 1);
        expectFrame(8'h7E, FRM + 1);
        send(0, 8'h81);
        send(FRM, 8'h7E);
        check("direct relaunch hold", 32'(ledIf.oHoldFull), 0);
        waitIdle();

`ifdef LED_UART_PARITY_EN
        // Parity bit values and frame length
        startTest();
        expectFrame(8'h07, 1);
        send(0, 8'h07);
        waitCyc(FRM + 1);
        check("parity frame length", 32'(ledIf.oBusy), 0);
        waitIdle();
        startTest();
        expectFrame(8'h03, 1);
        send(0, 8'h03);
        waitIdle();
`endif

        check("frames outstanding", 32'(expQ.size()), 0);
        check("overrun pulse count", 32'(ovCount), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/led_uart_tx.md
Name: led_uart_tx

Overview:
- Downstream consumer of the MiniAlu LED output register.
- Each time the core executes LED, the block captures the 8-bit value and serializes it as a UART frame (8N1, LSB first) on one TX pin, so a host can log program results.
- A one-entry holding buffer absorbs LED writes that arrive during a frame; newest value wins.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- iData  input  8  byte to send (MiniAlu LED register value).
- iValid  input  1  one-cycle strobe: iData is valid this cycle (driven from the LED-enable of the core).
- oTx  output  1  UART serial line, idle high.
- oBusy  output  1  high whenever state != IDLE.
- oHoldFull  output  1  holding buffer occupied.
- oOverrun  output  1  one-cycle pulse when a buffered byte is overwritten.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, oTx=1, oBusy=0, oHoldFull=0, oOverrun=0.
  - Bit counter, bit index and shift register cleared.
  - A partial frame is abandoned; the line returns high immediately.
- States:
  - IDLE → START → DATA → STOP, then back to IDLE or straight to START.
  - PARITY is inserted between DATA and STOP only with the optional feature.
- Launch:
  - In IDLE, iValid sampled high at edge N loads the shift register.
  - oTx=0 and oBusy=1 from after edge N (START), i.e. 1-cycle latency.
- Bit timing:
  - Each state lasts exactly CLKS_PER_BIT cycles, counted 0..CLKS_PER_BIT-1.
  - The state advances when the counter equals CLKS_PER_BIT-1.
- DATA:
  - 8 bits, bit 0 first; bit index 0..7.
  - Shift right at each bit boundary.
- STOP: oTx=1 for CLKS_PER_BIT cycles.
- Frame length: 10*CLKS_PER_BIT cycles without parity.
- End of STOP:
  - If the hold buffer is full, go directly to START with the hold byte, clear hold. There is no idle gap.
  - Otherwise go to IDLE.
- iValid while busy:
  - If hold is empty, the byte goes into hold and oHoldFull=1 next cycle.
  - If hold is full, hold is overwritten and oOverrun pulses for 1 cycle.
- Simultaneous event, iValid in the final STOP cycle:
  - If hold is full, the hold byte launches and the iValid byte becomes the new hold (no overrun).
  - If hold is empty, the iValid byte launches directly.
- iValid in IDLE with hold empty never sets oHoldFull.
- iData is ignored when iValid=0.
- No back-pressure; the block always accepts.

Optional Feature:
- Macro: LED_UART_PARITY_EN.
- Defined:
  - A PARITY state follows DATA, lasting CLKS_PER_BIT cycles.
  - oTx = XOR of the 8 data bits (even parity).
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 framing only, and no parity logic is synthesized.

Decomposition:
- Shared package/header (alongside the opcode definitions): state encodings, default CLKS_PER_BIT, frame-length constants.
- Sub-module uart_bit_timer:
  - Counter with a start/clear input.
  - Outputs a one-cycle tick at CLKS_PER_BIT-1.
  - Async reset.
  - Reused by a future receiver.

Test Plan (bench uses CLKS_PER_BIT=4):
- Reset mid-frame: send 0xFF, assert Reset at cycle 10 → oTx=1 within the same cycle, oBusy=0, oHoldFull=0. A subsequent 0x01 transmits a clean full frame.
- Single byte: iValid with 0xA5 at cycle 0 → oTx is 0 for cycles 1-4, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. oBusy falls at cycle 41.
- Back-to-back: 0x3C at cycle 0, 0xC3 at cycle 8 → oHoldFull=1 from cycle 9. The second START begins immediately after the first STOP (cycle 41), with no idle cycle.
- Overrun: 0x11 at cycle 0, 0x22 at 8, 0x33 at 12 → oOverrun pulses once at cycle 13. The second frame carries 0x33; 0x22 is never sent.
- Final-STOP collision: hold=0x55, iValid 0x66 in the last STOP cycle → 0x55 launches, hold=0x66, no overrun pulse. 0x66 follows immediately.
- LED_UART_PARITY_EN: send 0x07 → parity bit 1, frame 44 cycles. Send 0x03 → parity bit 0.
